// File: rtl/busca_de_instrucao.sv
// Fetch stage: drives the next PC, reads instruction memory over req/ack and
// hands {instruction, PC} to decode through a slot register with a one-entry skid.
module busca_de_instrucao #(
  parameter int LARGURA_END   = 26,
  parameter int LARGURA_INSTR = 32,
  parameter int MAX_ESPERA    = 255
) (
  input  logic                     clock,
  input  logic                     pc_reset,
  input  logic [LARGURA_END-1:0]   pc_atual,
  output logic [LARGURA_END-1:0]   endereco_proximo,
  output logic                     mem_req,
  output logic [LARGURA_END-1:0]   mem_endereco,
  input  logic                     mem_ack,
  input  logic [LARGURA_INSTR-1:0] mem_dado,
  output logic                     instr_valida,
  output logic [LARGURA_INSTR-1:0] instrucao,
  output logic [LARGURA_END-1:0]   instr_pc,
  input  logic                     decod_pronto,
  input  logic                     desvio_valido,
  input  logic [LARGURA_END-1:0]   desvio_endereco,
  output logic                     erro_busca
);

  typedef enum logic [1:0] {REQ, CHEIO, DESCARTE} estado_t;

  estado_t                  estado, estado_prox;
  logic [LARGURA_END-1:0]   end_pendente;
  logic [LARGURA_INSTR-1:0] skid_instr;
  logic [LARGURA_END-1:0]   skid_pc;
  logic [7:0]               espera;
  logic                     slot_livre;
  logic                     carrega_slot, carrega_skid, carrega_de_skid;

  assign slot_livre = !instr_valida || decod_pronto;

  always_comb begin
    estado_prox      = estado;
    mem_req          = 1'b0;
    mem_endereco     = pc_atual;
    endereco_proximo = pc_atual;
    carrega_slot     = 1'b0;
    carrega_skid     = 1'b0;
    carrega_de_skid  = 1'b0;
    unique case (estado)
      REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          endereco_proximo = pc_atual + LARGURA_END'(1);
          // an ack coinciding with a redirect is dropped here
          if (!desvio_valido) begin
            if (slot_livre) carrega_slot = 1'b1;
            else begin
              carrega_skid = 1'b1;
              estado_prox  = CHEIO;
            end
          end
        end else if (desvio_valido) begin
          estado_prox = DESCARTE;
        end
      end
      CHEIO: begin
        if (desvio_valido) estado_prox = REQ;
        else if (decod_pronto) begin
          carrega_de_skid = 1'b1;
          estado_prox     = REQ;
        end
      end
      DESCARTE: begin
        // finish the abandoned request so the memory sees a clean handshake
        mem_req      = 1'b1;
        mem_endereco = end_pendente;
        if (mem_ack && !desvio_valido) estado_prox = REQ;
      end
      default: estado_prox = REQ;
    endcase
    if (desvio_valido) endereco_proximo = desvio_endereco;
    if (pc_reset) begin
      mem_req          = 1'b0;
      endereco_proximo = '0;
    end
  end

  always_ff @(posedge clock or posedge pc_reset) begin
    if (pc_reset) begin
      estado       <= REQ;
      end_pendente <= '0;
      instr_valida <= 1'b0;
      instrucao    <= '0;
      instr_pc     <= '0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      espera       <= '0;
      erro_busca   <= 1'b0;
    end else begin
      estado <= estado_prox;
      if (estado == REQ) end_pendente <= pc_atual;

      if (desvio_valido) instr_valida <= 1'b0;
      else if (carrega_slot) begin
        instr_valida <= 1'b1;
        instrucao    <= mem_dado;
        instr_pc     <= pc_atual;
      end else if (carrega_de_skid) begin
        instr_valida <= 1'b1;
        instrucao    <= skid_instr;
        instr_pc     <= skid_pc;
      end else if (decod_pronto) instr_valida <= 1'b0;

      if (carrega_skid) begin
        skid_instr <= mem_dado;
        skid_pc    <= pc_atual;
      end

      // timeout flag is sticky; the fetch itself keeps waiting
      if (mem_req && mem_ack) espera <= '0;
      else if (mem_req) begin
        if (espera != 8'(MAX_ESPERA)) espera <= espera + 8'd1;
        if (espera == 8'(MAX_ESPERA - 1)) erro_busca <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_busca_de_instrucao.sv
// Directed bench for busca_de_instrucao; models the PC register that loads
// endereco_proximo every clock and checks against hand-computed values.
module tb_busca_de_instrucao;
  logic        clock = 1'b0;
  logic        pc_reset;
  logic [25:0] pc_atual;
  logic [25:0] endereco_proximo;
  logic        mem_req;
  logic [25:0] mem_endereco;
  logic        mem_ack;
  logic [31:0] mem_dado;
  logic        instr_valida;
  logic [31:0] instrucao;
  logic [25:0] instr_pc;
  logic        decod_pronto;
  logic        desvio_valido;
  logic [25:0] desvio_endereco;
  logic        erro_busca;

  int nvec = 0;
  int nerr = 0;

  busca_de_instrucao dut (
    .clock(clock), .pc_reset(pc_reset), .pc_atual(pc_atual),
    .endereco_proximo(endereco_proximo), .mem_req(mem_req), .mem_endereco(mem_endereco),
    .mem_ack(mem_ack), .mem_dado(mem_dado), .instr_valida(instr_valida),
    .instrucao(instrucao), .instr_pc(instr_pc), .decod_pronto(decod_pronto),
    .desvio_valido(desvio_valido), .desvio_endereco(desvio_endereco), .erro_busca(erro_busca)
  );

  always #5 clock = ~clock;

  // PC register in the environment
  always_ff @(posedge clock or posedge pc_reset)
    if (pc_reset) pc_atual <= '0;
    else          pc_atual <= endereco_proximo;

  function automatic logic [31:0] dat(input logic [25:0] a);
    return 32'hA500_0000 ^ {6'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  initial begin
    pc_reset = 1'b1; mem_ack = 1'b0; mem_dado = '0; decod_pronto = 1'b1;
    desvio_valido = 1'b0; desvio_endereco = 26'h0;
    #2;
    chk("rst_valida", instr_valida, 1'b0);
    chk("rst_instr", instrucao, 32'h0);
    chk("rst_pc", instr_pc, 26'h0);
    chk("rst_erro", erro_busca, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_prox", endereco_proximo, 26'h0);
    tick;
    pc_reset = 1'b0;

    // 1: zero-wait acks, one instruction per cycle
    mem_ack = 1'b1; mem_dado = dat(26'd0);
    #1;
    chk("t1_req", mem_req, 1'b1);
    chk("t1_end0", mem_endereco, 26'd0);
    chk("t1_prox0", endereco_proximo, 26'd1);
    chk("t1_valida_pre", instr_valida, 1'b0);
    tick;
    chk("t1_valida0", instr_valida, 1'b1);
    chk("t1_pc0", instr_pc, 26'd0);
    chk("t1_dado0", instrucao, dat(26'd0));
    for (int i = 1; i < 4; i++) begin
      mem_dado = dat(26'(i));
      #1;
      chk("t1_end", mem_endereco, 64'(i));
      tick;
      chk("t1_valida", instr_valida, 1'b1);
      chk("t1_pc", instr_pc, 64'(i));
      chk("t1_dado", instrucao, dat(26'(i)));
    end

    // 2: ack three cycles late at PC 4
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_hold", endereco_proximo, 26'd4);
      chk("t2_end", mem_endereco, 26'd4);
      chk("t2_req", mem_req, 1'b1);
      tick;
      chk("t2_valida_drop", instr_valida, 1'b0);
    end
    mem_ack = 1'b1; mem_dado = dat(26'd4);
    #1;
    chk("t2_prox", endereco_proximo, 26'd5);
    tick;
    chk("t2_pc", instr_pc, 26'd4);
    chk("t2_valida", instr_valida, 1'b1);

    // 3: decode stalls, ack at PC 5 goes to skid
    decod_pronto = 1'b0; mem_dado = dat(26'd5);
    #1;
    chk("t3_prox", endereco_proximo, 26'd6);
    tick;
    mem_ack = 1'b0;
    #1;
    chk("t3_req_off", mem_req, 1'b0);
    chk("t3_hold", endereco_proximo, 26'd6);
    chk("t3_slot_pc", instr_pc, 26'd4);
    tick;
    chk("t3_req_off2", mem_req, 1'b0);
    chk("t3_slot_pc2", instr_pc, 26'd4);
    chk("t3_slot_v2", instr_valida, 1'b1);
    decod_pronto = 1'b1;
    tick;
    chk("t3_skid_pc", instr_pc, 26'd5);
    chk("t3_skid_dado", instrucao, dat(26'd5));
    chk("t3_skid_v", instr_valida, 1'b1);
    #1;
    chk("t3_req_on", mem_req, 1'b1);
    chk("t3_end6", mem_endereco, 26'd6);

    // 4: redirect while waiting on PC 8
    mem_ack = 1'b1; mem_dado = dat(26'd6);
    tick;
    mem_dado = dat(26'd7);
    tick;
    chk("t4_pc7", instr_pc, 26'd7);
    mem_ack = 1'b0; decod_pronto = 1'b0;
    desvio_valido = 1'b1; desvio_endereco = 26'h100;
    #1;
    chk("t4_prox", endereco_proximo, 26'h100);
    tick;
    desvio_valido = 1'b0;
    chk("t4_squash", instr_valida, 1'b0);
    #1;
    chk("t4_desc_req", mem_req, 1'b1);
    chk("t4_desc_end", mem_endereco, 26'd8);
    tick;
    chk("t4_desc_end2", mem_endereco, 26'd8);
    mem_ack = 1'b1; mem_dado = 32'hDEAD_BEEF; decod_pronto = 1'b1;
    #1;
    chk("t4_desc_prox", endereco_proximo, 26'h100);
    tick;
    chk("t4_dropped", instr_valida, 1'b0);
    mem_ack = 1'b0;
    #1;
    chk("t4_new_end", mem_endereco, 26'h100);
    chk("t4_new_req", mem_req, 1'b1);
    mem_ack = 1'b1; mem_dado = dat(26'h100);
    tick;
    chk("t4_new_pc", instr_pc, 26'h100);
    chk("t4_new_v", instr_valida, 1'b1);

    // 5: redirect coinciding with ack, then PC wrap
    mem_dado = 32'hBAD0_0BAD; desvio_valido = 1'b1; desvio_endereco = 26'h3FFFFFF;
    #1;
    chk("t5_prox", endereco_proximo, 26'h3FFFFFF);
    tick;
    desvio_valido = 1'b0;
    chk("t5_dropped", instr_valida, 1'b0);
    mem_dado = dat(26'h3FFFFFF);
    #1;
    chk("t5_end", mem_endereco, 26'h3FFFFFF);
    chk("t5_wrap", endereco_proximo, 26'h0);
    tick;
    chk("t5_pc", instr_pc, 26'h3FFFFFF);
    chk("t5_v", instr_valida, 1'b1);

    // 6: timeout after 255 waiting cycles
    mem_ack = 1'b0;
    for (int k = 0; k < 254; k++) tick;
    chk("t6_erro_254", erro_busca, 1'b0);
    tick;
    chk("t6_erro_255", erro_busca, 1'b1);
    chk("t6_hold", endereco_proximo, 26'h0);
    mem_ack = 1'b1; mem_dado = dat(26'h0);
    tick;
    mem_ack = 1'b0;
    chk("t6_late_pc", instr_pc, 26'h0);
    chk("t6_sticky", erro_busca, 1'b1);
    tick;
    chk("t6_sticky2", erro_busca, 1'b1);
    pc_reset = 1'b1;
    #1;
    chk("t6_rst_erro", erro_busca, 1'b0);
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_prox", endereco_proximo, 26'h0);
    chk("t6_rst_v", instr_valida, 1'b0);
    tick;
    pc_reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
